// File: rtl/misr_sig_check_pkg.sv
// Shared DFT definitions for response compaction and pattern generation.
//   state_e    : sequencer states of the signature checker (IDLE/RUN/DONE)
//   DEF_POLY   : default feedback taps, x^16+x^12+x^3+x+1 (bit i = tap at stage i)
//   DEF_SEED   : default register value loaded at start and at reset
//   misr_step  : one Galois MISR update; the LFSR pattern generator uses the
//                same function so both ends share one polynomial convention
package misr_sig_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h100B;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // Widest register the helper supports; callers zero-extend into it and
    // truncate the result back to their own width.
    localparam int MISR_MAX_W = 64;

    // Shift left, fold the outgoing MSB back through the taps, then XOR in
    // the 3 response bits at the low end. Bits above 'width' are masked off.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] misr,
        input logic [2:0]            in,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic [5:0]            msb_idx;
        msb_idx = 6'(width - 1);
        if (width >= MISR_MAX_W) begin
            mask = '1;
        end else begin
            mask = (MISR_MAX_W'(1) << width) - MISR_MAX_W'(1);
        end
        nxt = (misr << 1) & mask;
        if (misr[msb_idx]) begin
            nxt = nxt ^ poly;
        end
        nxt = nxt ^ MISR_MAX_W'(in);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_sig_check_core.sv
// MISR register with its update logic.
//   clk, rst_n : clock, asynchronous active-low reset (register -> SEED)
//   load       : synchronous load of SEED (wins over en)
//   en         : fold 'in' into the register this cycle
//   in         : 3 response bits
//   misr       : current register contents
//   misr_next  : value the register takes at the next edge
module misr_core
    import misr_sig_check_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = W'(DEF_POLY),
    parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [2:0]   in,
    output logic [W-1:0] misr,
    output logic [W-1:0] misr_next
);

    logic [W-1:0]          misr_q;
    logic [W-1:0]          misr_d;
    logic [MISR_MAX_W-1:0] step;

    always_comb begin
        misr_d = misr_q;
        step   = misr_step(MISR_MAX_W'(misr_q), in, MISR_MAX_W'(POLY), W);
        if (load) begin
            misr_d = SEED;
        end else if (en) begin
            misr_d = step[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign misr      = misr_q;
    assign misr_next = misr_d;

endmodule

// File: rtl/misr_sig_check.sv
// MISR response compactor with built-in golden-signature check.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a run (taken in IDLE and DONE)
//   abort       : cancel to IDLE, clears pass, keeps MISR contents; beats start
//   resp        : 3 response bits from the circuit under test
//   resp_valid  : resp is a sample to compact this cycle (RUN only)
//   golden      : expected signature, stable from start until done
//   busy / done : high in RUN / DONE
//   pass        : final signature matched golden (meaningful while done)
//   signature   : current MISR contents
//   state_dbg   : current sequencer state
module misr_sig_check
    import misr_sig_check_pkg::*;
#(
    parameter int                MISR_W   = 16,
    parameter logic [MISR_W-1:0] POLY     = MISR_W'(DEF_POLY),
    parameter logic [MISR_W-1:0] SEED     = MISR_W'(DEF_SEED),
    parameter int                N_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        resp,
    input  logic              resp_valid,
    input  logic [MISR_W-1:0] golden,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output state_e            state_dbg
);

    localparam int               CNT_W = $clog2(N_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pass_q,  pass_d;
    logic              core_load;
    logic              core_en;
    logic [MISR_W-1:0] misr_next;

    misr_core #(
        .W    (MISR_W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .en        (core_en),
        .in        (resp),
        .misr      (signature),
        .misr_next (misr_next)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        core_load = 1'b0;
        core_en   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        core_load = 1'b1;
                        count_d   = '0;
                        pass_d    = 1'b0;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        core_en = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        // Last sample: compare against the value being
                        // written this edge, so pass is ready with done.
                        if (count_q == LAST) begin
                            state_d = ST_DONE;
                            pass_d  = (misr_next == golden);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_misr_sig_check.sv
// Bench for misr_sig_check. Three instances cover the parameter sets used
// by the directed vectors:
//   d0: N_CYCLES=32, SEED=0x0000
//   d1: N_CYCLES=4,  SEED=0x0000
//   d2: N_CYCLES=1,  SEED=0x8000
// Expected {id, pass, signature} entries are queued when a run is issued; a
// monitor pops one whenever an instance's done rises.
module tb_misr_sig_check;
    import misr_sig_check_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_s   [3];
    logic        abort_s   [3];
    logic [2:0]  resp_s    [3];
    logic        valid_s   [3];
    logic [15:0] golden_s  [3];
    logic        busy_s    [3];
    logic        done_s    [3];
    logic        pass_s    [3];
    logic [15:0] sig_s     [3];
    state_e      state_s   [3];
    logic        done_prev [3];

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];
    logic [2:0]  stim_q[$];

    misr_sig_check #(.MISR_W(16), .POLY(16'h100B), .SEED(16'h0000), .N_CYCLES(32)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .resp(resp_s[0]), .resp_valid(valid_s[0]), .golden(golden_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .signature(sig_s[0]), .state_dbg(state_s[0]));

    misr_sig_check #(.MISR_W(16), .POLY(16'h100B), .SEED(16'h0000), .N_CYCLES(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .resp(resp_s[1]), .resp_valid(valid_s[1]), .golden(golden_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .signature(sig_s[1]), .state_dbg(state_s[1]));

    misr_sig_check #(.MISR_W(16), .POLY(16'h100B), .SEED(16'h8000), .N_CYCLES(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
        .resp(resp_s[2]), .resp_valid(valid_s[2]), .golden(golden_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
        .signature(sig_s[2]), .state_dbg(state_s[2]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        for (int i = 0; i < 3; i++) done_prev[i] = 1'b0;
    end

    always @(negedge clk) begin
        logic [18:0] e;
        for (int d = 0; d < 3; d++) begin
            if (done_s[d] === 1'b1 && done_prev[d] !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dut_id",    32'(d),         32'(e[18:17]));
                    check("sb_pass",      32'(pass_s[d]), 32'(e[16]));
                    check("sb_signature", 32'(sig_s[d]),  32'(e[15:0]));
                end
            end
            done_prev[d] = done_s[d];
        end
    end

    // Driver tasks
    task automatic push_exp(input int d, input logic p, input logic [15:0] sig);
        exp_q.push_back({2'(d), p, sig});
    endtask

    task automatic do_start(input int d);
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        check("busy_after_start", 32'(busy_s[d]), 32'd1);
        check("done_after_start", 32'(done_s[d]), 32'd0);
    endtask

    task automatic do_abort(input int d);
        abort_s[d] = 1'b1;
        @(posedge clk); #1;
        abort_s[d] = 1'b0;
    endtask

    // Consume stim_q; with gaps, an idle (resp_valid=0) cycle precedes each sample.
    task automatic run_samples(input int d, input bit gaps, input bit expect_done);
        while (stim_q.size() > 0) begin
            if (gaps) begin
                valid_s[d] = 1'b0;
                resp_s[d]  = 3'b111;
                @(posedge clk); #1;
            end
            if (expect_done && stim_q.size() == 1)
                check("done_before_last", 32'(done_s[d]), 32'd0);
            resp_s[d]  = stim_q.pop_front();
            valid_s[d] = 1'b1;
            @(posedge clk); #1;
            valid_s[d] = 1'b0;
        end
        if (expect_done) begin
            check("done_latency", 32'(done_s[d]), 32'd1);
            check("busy_at_done", 32'(busy_s[d]), 32'd0);
        end
    endtask

    task automatic check_idle(input string name, input int d, input logic [15:0] sig);
        check({name, "_busy"},  32'(busy_s[d]),  32'd0);
        check({name, "_done"},  32'(done_s[d]),  32'd0);
        check({name, "_pass"},  32'(pass_s[d]),  32'd0);
        check({name, "_sig"},   32'(sig_s[d]),   32'(sig));
        check({name, "_state"}, 32'(state_s[d]), 32'(ST_IDLE));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; abort_s[d] = 1'b0; resp_s[d] = 3'b000;
            valid_s[d] = 1'b0; golden_s[d] = 16'h0000;
        end
        #23;
        check_idle("reset_d0", 0, 16'h0000);
        check_idle("reset_d1", 1, 16'h0000);
        check_idle("reset_d2", 2, 16'h8000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-run: 5 samples of 001 -> 0x001F, then async reset.
        do_start(0);
        for (int i = 0; i < 5; i++) stim_q.push_back(3'b001);
        run_samples(0, 1'b0, 1'b0);
        check("midrun_sig", 32'(sig_s[0]), 32'h001F);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset", 0, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero run, 32 samples.
        golden_s[0] = 16'h0000;
        push_exp(0, 1'b1, 16'h0000);
        do_start(0);
        for (int i = 0; i < 32; i++) stim_q.push_back(3'b000);
        run_samples(0, 1'b0, 1'b1);

        // Abort after 10 of 32 samples of 001 -> MISR keeps 0x03FF.
        do_start(0);
        for (int i = 0; i < 10; i++) stim_q.push_back(3'b001);
        run_samples(0, 1'b0, 1'b0);
        do_abort(0);
        check_idle("abort_run", 0, 16'h03FF);

        // Shift and match: 001,000,000,000 -> 0x0008.
        golden_s[1] = 16'h0008;
        push_exp(1, 1'b1, 16'h0008);
        do_start(1);
        stim_q = '{3'b001, 3'b000, 3'b000, 3'b000};
        run_samples(1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("done_held", 32'(done_s[1]), 32'd1);
        check("pass_held", 32'(pass_s[1]), 32'd1);

        // Restart from DONE with golden 0x0009 -> mismatch; run starts from SEED.
        golden_s[1] = 16'h0009;
        push_exp(1, 1'b0, 16'h0008);
        do_start(1);
        stim_q = '{3'b001, 3'b000, 3'b000, 3'b000};
        run_samples(1, 1'b0, 1'b1);

        // Abort from DONE clears pass, signature kept.
        golden_s[1] = 16'h0008;
        push_exp(1, 1'b1, 16'h0008);
        do_start(1);
        stim_q = '{3'b001, 3'b000, 3'b000, 3'b000};
        run_samples(1, 1'b0, 1'b1);
        do_abort(1);
        check_idle("abort_done", 1, 16'h0008);

        // Valid gaps: same samples, same signature.
        push_exp(1, 1'b1, 16'h0008);
        do_start(1);
        stim_q = '{3'b001, 3'b000, 3'b000, 3'b000};
        run_samples(1, 1'b1, 1'b1);

        // Mixed pattern: 111,101,010,110 -> 0x0007,0x000B,0x0014,0x002E.
        golden_s[1] = 16'h002E;
        push_exp(1, 1'b1, 16'h002E);
        do_start(1);
        stim_q = '{3'b111, 3'b101, 3'b010, 3'b110};
        run_samples(1, 1'b0, 1'b1);

        // Feedback wrap: SEED 0x8000, one sample 000 -> 0x100B.
        golden_s[2] = 16'h100B;
        push_exp(2, 1'b1, 16'h100B);
        do_start(2);
        stim_q = '{3'b000};
        run_samples(2, 1'b0, 1'b1);

        // Feedback plus input: 101 -> 0x100E, golden unchanged -> fail.
        push_exp(2, 1'b0, 16'h100E);
        do_start(2);
        stim_q = '{3'b101};
        run_samples(2, 1'b0, 1'b1);

        // start and abort together in IDLE: stays IDLE.
        do_abort(2);
        check_idle("abort_d2", 2, 16'h100E);
        start_s[2] = 1'b1; abort_s[2] = 1'b1;
        @(posedge clk); #1;
        start_s[2] = 1'b0; abort_s[2] = 1'b0;
        check_idle("start_abort_idle", 2, 16'h100E);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/misr_sig_check.md
# misr_sig_check

Multiple-input signature register (MISR) response compactor with built-in pass/fail check, the stage directly downstream of the 3-output scan/test circuit. Each valid clock it folds the circuit's 3 response bits into a Galois MISR. After a programmed number of samples it compares the signature against a golden value and reports pass/fail. A BIST sequencer starts it and reads `done`/`pass`.

## Interface
- `MISR_W`, 16: signature width, ≥4.
- `POLY`, 16'h100B: feedback taps (x^16+x^12+x^3+x+1); bit i set means tap at stage i.
- `SEED`, 16'h0000: MISR value loaded at start and at reset.
- `N_CYCLES`, 32: number of accepted response samples per run, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled in IDLE and DONE.
- `abort`  in  1  cancel the run, return to IDLE.
- `resp`  in  3  response bits from the circuit under test.
- `resp_valid`  in  1  `resp` is a sample to compact this cycle.
- `golden`  in  MISR_W  expected signature; held stable from start until `done`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  signature matched golden; meaningful only while `done`=1.
- `signature`  out  MISR_W  current MISR contents.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → load MISR←SEED, count←0, go RUN.
  - `resp_valid` ignored.
- RUN, each cycle with `resp_valid`=1:
  - fb = misr[MISR_W-1].
  - misr ← {misr[MISR_W-2:0],0} ^ (fb ? POLY : 0) ^ zero-extended `resp`.
  - count++.
  - `resp_valid`=0 → misr and count hold.
  - `start` ignored.
- Completion: on the sample where count == N_CYCLES-1:
  - the MISR update still applies;
  - state ← DONE;
  - `pass` ← (next misr == golden).
- DONE:
  - outputs are held;
  - `start`=1 → reload SEED, clear count, go RUN directly.
- `abort`=1 in any state → IDLE next edge, `pass` cleared, MISR retains its value. `abort` beats `start` when both are asserted.
- Counter width is $clog2(N_CYCLES+1). The counter never wraps, because the run terminates at N_CYCLES.
- XOR arithmetic only; no carries. All outputs are registered.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `signature`=SEED, state IDLE, count 0.
- Asynchronous assert; mid-run reset discards the run.
- `start` at edge k → `busy`=1 after k. The first sample accepted is at edge k+1 at the earliest.
- Nth accepted sample at edge m → `done`=1, `busy`=0, `pass` valid and `signature` final, all after m. This gives 1-cycle latency from the last sample.
- `done`/`pass` stay high until `start`, `abort` or reset.
- `start` in DONE at edge j → `done`=0 and `busy`=1 after j.

## Structure
- Shared DFT package holds:
  - the state enum (IDLE/RUN/DONE);
  - the default POLY/SEED constants;
  - a `misr_step(misr, in, poly)` function, so the upstream LFSR pattern generator reuses the same polynomial convention.
- One natural sub-module, `misr_core`: register plus update, with an enable and a synchronous load of SEED. The FSM, counter and comparator live in the top level.

## Test plan
- **All-zero run.** Reset; N_CYCLES=32, golden=0x0000, start, 32 samples of `resp`=000 → `done`=1 one cycle after the 32nd sample, `signature`=0x0000, `pass`=1.
- **Shift and match.** N_CYCLES=4, SEED=0; samples 001,000,000,000 → signature 0x0008. golden=0x0008 gives `pass`=1; golden=0x0009 gives `pass`=0.
- **Feedback wrap.** SEED=0x8000, N_CYCLES=1, `resp`=000 → signature 0x100B, exercising the MSB feedback path.
- **Valid gaps.** N_CYCLES=4 with `resp_valid` low on alternate cycles → `done` rises exactly one cycle after the 4th valid sample; signature equals the no-gap case.
- **Abort.** `abort` after 10 of 32 samples → IDLE, `busy`=0, `done`=0, `pass`=0. `start` and `abort` asserted together in IDLE → state stays IDLE.
- **Reset mid-run.** `rst_n` low mid-run → all outputs at reset values immediately, with no clock edge needed. A following start/run produces the correct signature. Restart from DONE via `start` → the new run begins from SEED.
